// File: rtl/frame_buffer_write_arbiter.sv
// Shares the back-buffer write port between the sprite, vector and clear engines and sequences buffer switches.
// Build macro FB_ARB_FIXED_PRIORITY_EN: fixed priority (requester 2 highest) replaces round robin.
module frame_buffer_write_arbiter #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 4,
    parameter int REQUESTERS = 3
) (
    input  logic                             spi_clock_in,
    input  logic                             spi_reset_n_in,
    input  logic [REQUESTERS-1:0]            request_valid_in,
    output logic [REQUESTERS-1:0]            request_ready_out,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] request_address_in,
    input  logic [REQUESTERS*DATA_WIDTH-1:0] request_data_in,
    output logic                             write_enable_out,
    output logic [ADDR_WIDTH-1:0]            write_address_out,
    output logic [DATA_WIDTH-1:0]            write_data_out,
    input  logic                             switch_request_in,
    output logic                             switch_pulse_out,
    input  logic                             switch_done_in,
    output logic                             busy_out
);

    localparam int IDX_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    wait_armed_r;
    logic                    arb_enable_s;
    logic                    found_s;
    logic [IDX_WIDTH-1:0]    grant_idx_s;
    logic [REQUESTERS-1:0]   grant_s;
    logic                    transfer_s;
    logic [ADDR_WIDTH-1:0]   sel_address_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic                    write_enable_r;
    logic [ADDR_WIDTH-1:0]   write_address_r;
    logic [DATA_WIDTH-1:0]   write_data_r;
    logic                    switch_pulse_r;
    logic                    busy_r;

    // Grants are only issued in IDLE and never in the cycle a switch is requested.
    always_comb begin
        if ((state_r == ST_IDLE) && !switch_request_in) begin
            arb_enable_s = 1'b1;
        end else begin
            arb_enable_s = 1'b0;
        end
    end

`ifdef FB_ARB_FIXED_PRIORITY_EN
    // Fixed priority search from the highest index downwards.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        if (arb_enable_s) begin
            for (int k = REQUESTERS - 1; k >= 0; k--) begin
                if (!found_s && request_valid_in[IDX_WIDTH'(k)]) begin
                    found_s     = 1'b1;
                    grant_idx_s = IDX_WIDTH'(k);
                end else begin
                    grant_idx_s = grant_idx_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end
`else
    logic [IDX_WIDTH-1:0] pointer_r;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        logic [IDX_WIDTH-1:0] cand_v;
        found_s     = 1'b0;
        grant_idx_s = '0;
        cand_v      = '0;
        if (arb_enable_s) begin
            for (int k = 1; k <= REQUESTERS; k++) begin
                cand_v = IDX_WIDTH'((int'(pointer_r) + k) % REQUESTERS);
                if (!found_s && request_valid_in[cand_v]) begin
                    found_s     = 1'b1;
                    grant_idx_s = cand_v;
                end else begin
                    grant_idx_s = grant_idx_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

    // Pointer moves only on a transfer; reset value lets requester 0 win first.
    always_ff @(posedge spi_clock_in or negedge spi_reset_n_in) begin
        if (!spi_reset_n_in) begin
            pointer_r <= IDX_WIDTH'(REQUESTERS - 1);
        end else if (transfer_s) begin
            pointer_r <= grant_idx_s;
        end else begin
            pointer_r <= pointer_r;
        end
    end
`endif

    // One-hot grant vector and the address/data of the winning requester.
    always_comb begin
        grant_s       = '0;
        sel_address_s = '0;
        sel_data_s    = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (found_s && (grant_idx_s == IDX_WIDTH'(k))) begin
                grant_s[k]    = 1'b1;
                sel_address_s = request_address_in[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data_s    = request_data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                grant_s[k] = 1'b0;
            end
        end
    end

    assign transfer_s        = |grant_s;
    assign request_ready_out = grant_s;

    // Switch sequencer next-state; done is ignored in the first WAIT cycle to reject a stale level.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (switch_request_in) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRAIN:  next_state_s = ST_SWITCH;
            ST_SWITCH: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_armed_r && switch_done_in) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register plus registered pulse/busy derived from the upcoming state.
    always_ff @(posedge spi_clock_in or negedge spi_reset_n_in) begin
        if (!spi_reset_n_in) begin
            state_r        <= ST_IDLE;
            wait_armed_r   <= 1'b0;
            switch_pulse_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            wait_armed_r   <= (state_r == ST_WAIT);
            switch_pulse_r <= (next_state_s == ST_SWITCH);
            busy_r         <= (next_state_s != ST_IDLE);
        end
    end

    // Registered write port: one strobe per transfer, address/data hold otherwise.
    always_ff @(posedge spi_clock_in or negedge spi_reset_n_in) begin
        if (!spi_reset_n_in) begin
            write_enable_r  <= 1'b0;
            write_address_r <= '0;
            write_data_r    <= '0;
        end else if (transfer_s) begin
            write_enable_r  <= 1'b1;
            write_address_r <= sel_address_s;
            write_data_r    <= sel_data_s;
        end else begin
            write_enable_r  <= 1'b0;
            write_address_r <= write_address_r;
            write_data_r    <= write_data_r;
        end
    end

    assign write_enable_out  = write_enable_r;
    assign write_address_out = write_address_r;
    assign write_data_out    = write_data_r;
    assign switch_pulse_out  = switch_pulse_r;
    assign busy_out          = busy_r;

endmodule
